dec_countdown_ctrl: RTL and testbench

- Sequential countdown stage that sits directly downstream of the DEC datapath component and consumes its result.
- Loads a start value through a valid/ready handshake, then registers the DEC output back into its count register on each enabled cycle.
- Signals completion when the count reaches zero and holds the done indication until it is acknowledged.
- Used as a loop/iteration controller in the scheduled datapaths built from the team's component library.

---
 rtl/dec_countdown_ctrl_pkg.sv | 12 +
 rtl/dec_countdown_ctrl_dec.sv | 17 +
 rtl/dec_countdown_ctrl.sv | 125 ++++++++++++
 tb/tb_dec_countdown_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: FSM state encoding.
package dec_countdown_ctrl_pkg;

  // Controller states. The encoding values are fixed because other
  // blocks in the datapath library compare against them directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : dec_countdown_ctrl_pkg

// File: rtl/dec_countdown_ctrl_dec.sv
// DEC component: unsigned decrement by one at DATAWIDTH bits.
// The caller is responsible for never presenting zero.
module dec_countdown_ctrl_dec #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] d
);

  localparam logic [DATAWIDTH-1:0] ONE_C = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  // Pure combinational decrement.
  always_comb begin
    d = a - ONE_C;
  end

endmodule : dec_countdown_ctrl_dec

// File: rtl/dec_countdown_ctrl.sv
// Countdown controller: loads a start value over valid/ready, then feeds
// the DEC result back into the count register on every enabled cycle.
// done is a level held until done_ack. All outputs are Moore-decoded.
module dec_countdown_ctrl
  import dec_countdown_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  input  logic                 en,
  input  logic                 abort,
  output logic [DATAWIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  input  logic                 done_ack
);

  localparam logic [DATAWIDTH-1:0] ZERO_C = {DATAWIDTH{1'b0}};
  localparam logic [DATAWIDTH-1:0] ONE_C  = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q;
  state_e                 state_d;
  logic [DATAWIDTH-1:0]   count_q;
  logic [DATAWIDTH-1:0]   count_d;
  logic [DATAWIDTH-1:0]   dec_count_s;

  // Next-count candidate comes from the shared DEC component.
  dec_countdown_ctrl_dec #(
    .DATAWIDTH (DATAWIDTH)
  ) u_dec (
    .a (count_q),
    .d (dec_count_s)
  );

  // State and count registers; Rst low clears them immediately.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      count_q <= ZERO_C;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_data != ZERO_C) begin
            count_d = in_data;
            state_d = ST_RUN;
          end else begin
            // A zero start value is already finished: skip RUN.
            count_d = ZERO_C;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // abort outranks en, including on the final count.
          count_d = ZERO_C;
          state_d = ST_IDLE;
        end else if (en) begin
          if (count_q > ONE_C) begin
            count_d = dec_count_s;
          end else begin
            // Last step (count==1) lands on zero; treating a stray zero
            // the same way keeps DEC from ever wrapping.
            count_d = ZERO_C;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Load requests are ignored here even when acked in the same cycle.
        count_d = ZERO_C;
        if (done_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        count_d = ZERO_C;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and count.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    count    = count_q;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule : dec_countdown_ctrl

// File: tb/tb_dec_countdown_ctrl.sv
// Self-checking bench for dec_countdown_ctrl: a table of per-cycle vectors
// with hand-derived expectations, plus sequences for reset, max load and
// the long countdown. Expectations go through a scoreboard queue.
module tb_dec_countdown_ctrl;

  localparam int DW = 8;

  logic          Clk;
  logic          Rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          en;
  logic          abort;
  logic [DW-1:0] count;
  logic          busy;
  logic          done;
  logic          done_ack;

  int n_cmp;
  int n_err;

  dec_countdown_ctrl #(.DATAWIDTH(DW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .en       (en),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .done_ack (done_ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic          en;
    logic          abort;
    logic          ack;
    logic [DW-1:0] e_count;
    logic          e_busy;
    logic          e_done;
    logic          e_rdy;
  } vec_t;

  typedef struct {
    int            id;
    logic [DW-1:0] e_count;
    logic          e_busy;
    logic          e_done;
    logic          e_rdy;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[33];

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic e, logic ab, logic ak,
                              logic [DW-1:0] ec, logic eb, logic ed, logic er);
    vec_t r;
    r.vld = v; r.data = d; r.en = e; r.abort = ab; r.ack = ak;
    r.e_count = ec; r.e_busy = eb; r.e_done = ed; r.e_rdy = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] ec, input logic eb,
                       input logic ed, input logic er);
    n_cmp++;
    if (count !== ec || busy !== eb || done !== ed || in_ready !== er) begin
      n_err++;
      $display("FAIL %s: got count=%0d busy=%b done=%b in_ready=%b, want count=%0d busy=%b done=%b in_ready=%b",
               name, count, busy, done, in_ready, ec, eb, ed, er);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic e, input logic ab,
                      input logic ak, input logic [DW-1:0] ec, input logic eb,
                      input logic ed, input logic er, input int id);
    exp_t x;
    in_valid = v; in_data = d; en = e; abort = ab; done_ack = ak;
    x.id = id; x.e_count = ec; x.e_busy = eb; x.e_done = ed; x.e_rdy = er;
    sb_q.push_back(x);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_underflow: got empty queue, want entry %0d", id);
    end else begin
      x = sb_q.pop_front();
      check($sformatf("vec%0d", x.id), x.e_count, x.e_busy, x.e_done, x.e_rdy);
    end
  endtask

  initial begin
    int exp_c;
    n_cmp = 0;
    n_err = 0;
    in_valid = 1'b0; in_data = 8'd0; en = 1'b0; abort = 1'b0; done_ack = 1'b0;

    // Vector table: inputs applied before an edge, outputs expected after it.
    // Basic countdown from 3.
    vecs[0]  = mk(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    // Pause: load 4, en 1,0,0,1,1,1.
    vecs[6]  = mk(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    // Zero load goes straight to DONE.
    vecs[14] = mk(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    // Abort beats en on the last count; then a new load of 2.
    vecs[16] = mk(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    vecs[19] = mk(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    vecs[22] = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    // Handshake: in_valid/7 held through RUN and DONE; ack+valid in DONE.
    vecs[23] = mk(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
    vecs[24] = mk(1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    vecs[25] = mk(1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    vecs[26] = mk(1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
    vecs[27] = mk(1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    vecs[28] = mk(1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    vecs[29] = mk(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    vecs[30] = mk(1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    vecs[31] = mk(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
    vecs[32] = mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    // Power-on reset.
    Rst = 1'b0;
    #1;
    check("por_reset", 8'd0, 1'b0, 1'b0, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("por_release", 8'd0, 1'b0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;

    for (int i = 0; i < 33; i++) begin
      step(vecs[i].vld, vecs[i].data, vecs[i].en, vecs[i].abort, vecs[i].ack,
           vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_rdy, i);
    end

    // Max load: 255 enabled cycles to done, no wrap.
    step(1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 100);
    for (int k = 1; k <= 255; k++) begin
      exp_c = 255 - k;
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, exp_c[DW-1:0], (exp_c != 0), (exp_c == 0), 1'b0, 100 + k);
    end
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 400);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 401);

    // Asynchronous reset mid-RUN with count=5.
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 500);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 501);
    en = 1'b1;
    #2;
    Rst = 1'b0;
    #1;
    n_cmp++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_run: got count=%0d busy=%b done=%b, want count=0 busy=0 done=0",
               count, busy, done);
    end
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    en = 1'b0;
    #1;
    check("rst_run_release", 8'd0, 1'b0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;

    // Asynchronous reset mid-DONE.
    step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 600);
    in_valid = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
      n_err++;
      $display("FAIL rst_mid_done: got count=%0d busy=%b done=%b, want count=0 busy=0 done=0",
               count, busy, done);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 601);
    step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0, 602);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dec_countdown_ctrl
